muldiv_unit: RTL

Multi-cycle multiply/divide controller for the five-stage MIPS pipeline. It owns the HI/LO register pair and sequences MULT/MULTU/DIV/DIVU over a programmable number of cycles. It commits MTHI/MTLO writes and exports a stall request that the hazard unit ORs into the global stall. It sits beside the ALU in EX: operands come from the forwarded RS/RT values of EX, and HI/LO feed the EX result mux for MFHI/MFLO.

---
 rtl/mips_md_pkg.sv | 35 +++
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/md_compute.sv | 66 ++++++
 rtl/muldiv_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/mips_md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// controller state, latched request payload and default latencies.
package mips_md_pkg;

  localparam int unsigned MD_OP_W         = 3;
  localparam int unsigned MD_DATA_W       = 32;
  localparam int unsigned MUL_CYCLES_DEF  = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Operation captured at start and held for the whole busy period
  typedef struct packed {
    md_op_e               op;
    logic [MD_DATA_W-1:0] a;
    logic [MD_DATA_W-1:0] b;
  } md_req_t;

  function automatic logic is_arith(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface muldiv_unit_if import mips_md_pkg::*; ();

  logic                 start;
  md_op_e               op;
  logic [MD_DATA_W-1:0] A;
  logic [MD_DATA_W-1:0] B;
  logic                 use_md_D;
  logic                 busy;
  logic                 stall_md;
  logic [MD_DATA_W-1:0] HI;
  logic [MD_DATA_W-1:0] LO;

  modport master (
    output start, op, A, B, use_md_D,
    input  busy, stall_md, HI, LO
  );

  modport slave (
    input  start, op, A, B, use_md_D,
    output busy, stall_md, HI, LO
  );

endinterface

// File: rtl/md_compute.sv
// Combinational HI/LO result for a latched multiply/divide request,
// including the divide-by-zero and signed-overflow cases.
module md_compute import mips_md_pkg::*; (
  input  md_req_t              req,
  output logic [MD_DATA_W-1:0] hi,
  output logic [MD_DATA_W-1:0] lo,
  output logic                 commit_en
);

  logic signed [2*MD_DATA_W-1:0] prod_s;
  logic        [2*MD_DATA_W-1:0] prod_u;
  logic signed [MD_DATA_W-1:0]   dvd_s;
  logic signed [MD_DATA_W-1:0]   dvs_s;
  logic signed [MD_DATA_W-1:0]   quo_s;
  logic signed [MD_DATA_W-1:0]   rem_s;
  logic        [MD_DATA_W-1:0]   dvs_u;
  logic        [MD_DATA_W-1:0]   quo_u;
  logic        [MD_DATA_W-1:0]   rem_u;
  logic                          div_zero;
  logic                          div_ovf;
  logic                          is_div;

  always_comb begin
    div_zero = (req.b == '0);
    div_ovf  = (req.a == 32'h8000_0000) && (req.b == 32'hFFFF_FFFF);
    is_div   = (req.op == MD_DIV) || (req.op == MD_DIVU);

    prod_s = $signed({{MD_DATA_W{req.a[MD_DATA_W-1]}}, req.a})
           * $signed({{MD_DATA_W{req.b[MD_DATA_W-1]}}, req.b});
    prod_u = {{MD_DATA_W{1'b0}}, req.a} * {{MD_DATA_W{1'b0}}, req.b};

    // Divisors are steered away from 0 and -1 overflow so the dividers never see them
    dvd_s = $signed(req.a);
    dvs_s = (div_zero || div_ovf) ? 32'sd1 : $signed(req.b);
    quo_s = dvd_s / dvs_s;
    rem_s = dvd_s % dvs_s;

    dvs_u = div_zero ? 32'd1 : req.b;
    quo_u = req.a / dvs_u;
    rem_u = req.a % dvs_u;

    hi = '0;
    lo = '0;
    unique case (req.op)
      MD_MULT:  {hi, lo} = prod_s;
      MD_MULTU: {hi, lo} = prod_u;
      MD_DIV: begin
        if (div_ovf) begin
          hi = '0;
          lo = 32'h8000_0000;
        end else begin
          hi = rem_s;
          lo = quo_s;
        end
      end
      MD_DIVU: begin
        hi = rem_u;
        lo = quo_u;
      end
      default: ;
    endcase

    commit_en = is_arith(req.op) && !(is_div && div_zero);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV sequencer owning architectural HI/LO; raises a
// combinational stall while a D-stage md instruction must wait.
module muldiv_unit import mips_md_pkg::*; #(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  md
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e            state;
  md_state_e            state_nxt;
  logic [CNT_W-1:0]     cnt;
  md_req_t              req;
  logic [MD_DATA_W-1:0] hi_q;
  logic [MD_DATA_W-1:0] lo_q;
  logic [MD_DATA_W-1:0] res_hi;
  logic [MD_DATA_W-1:0] res_lo;
  logic                 commit_en;
  logic                 launch_c;
  logic                 last_c;
  logic                 mthi_c;
  logic                 mtlo_c;

  md_compute u_compute (
    .req       (req),
    .hi        (res_hi),
    .lo        (res_lo),
    .commit_en (commit_en)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      MD_IDLE: if (md.start && is_arith(md.op)) state_nxt = MD_RUN;
      MD_RUN:  if (cnt == CNT_W'(1))            state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Decoded controls and outputs
  always_comb begin
    launch_c    = 1'b0;
    last_c      = 1'b0;
    mthi_c      = 1'b0;
    mtlo_c      = 1'b0;
    md.busy     = 1'b0;
    unique case (state)
      MD_IDLE: begin
        launch_c = md.start && is_arith(md.op);
        mthi_c   = md.start && (md.op == MD_MTHI);
        mtlo_c   = md.start && (md.op == MD_MTLO);
      end
      MD_RUN: begin
        md.busy = 1'b1;
        last_c  = (cnt == CNT_W'(1));
      end
      default: ;
    endcase
    md.stall_md = md.use_md_D && (md.busy || md.start);
  end

  // Operand latch and busy-period counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      req <= '0;
    end else if (launch_c) begin
      req <= '{op: md.op, a: md.A, b: md.B};
      cnt <= ((md.op == MD_MULT) || (md.op == MD_MULTU)) ? CNT_W'(MUL_CYCLES)
                                                          : CNT_W'(DIV_CYCLES);
    end else if (state == MD_RUN) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Architectural HI/LO: only final results and MTHI/MTLO ever land here
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last_c) begin
      if (commit_en) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else begin
      if (mthi_c) hi_q <= md.A;
      if (mtlo_c) lo_q <= md.A;
    end
  end

  assign md.HI = hi_q;
  assign md.LO = lo_q;

endmodule
